// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_ctrl
// Brief    : IEEE 1149.1 TAP FSM, instruction register, BYPASS/IDCODE DRs and
//            TDO mux. Define JTAG_IDCODE_EN to include the IDCODE register.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl #(
    parameter int              IR_W       = 3,
    parameter logic [31:0]     IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_W-1:0] OP_SAMPLE  = IR_W'(3'b001),
    parameter logic [IR_W-1:0] OP_EXTEST  = IR_W'(3'b010),
    parameter logic [IR_W-1:0] OP_INTEST  = IR_W'(3'b011),
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(3'b100),
    parameter logic [IR_W-1:0] OP_BIST    = IR_W'(3'b101)
) (
    input  logic            TCK,
    input  logic            TRSTn,
    input  logic            TMS,
    input  logic            TDI,
    output logic            TDO,
    output logic            TDO_en,
    input  logic            ext_tdo,
    output logic [IR_W-1:0] ir_q,
    output logic            sel_sample,
    output logic            sel_extest,
    output logic            sel_intest,
    output logic            sel_bist,
    output logic            capture_dr,
    output logic            shift_dr,
    output logic            update_dr,
    output logic [3:0]      tap_state,
    output logic            tlr
);

    typedef enum logic [3:0] {
        S_TLR     = 4'hF, S_RTI     = 4'hC,
        S_SEL_DR  = 4'h7, S_CAP_DR  = 4'h6, S_SH_DR  = 4'h2, S_EX1_DR = 4'h1,
        S_PAU_DR  = 4'h3, S_EX2_DR  = 4'h0, S_UPD_DR = 4'h5,
        S_SEL_IR  = 4'h4, S_CAP_IR  = 4'hE, S_SH_IR  = 4'hA, S_EX1_IR = 4'h9,
        S_PAU_IR  = 4'hB, S_EX2_IR  = 4'h8, S_UPD_IR = 4'hD
    } tap_state_t;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] c_ir_rst = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] c_ir_rst = {IR_W{1'b1}};
`endif

    tap_state_t      r_state;
    tap_state_t      w_state_nxt;
    logic [IR_W-1:0] r_ir_sh;
    logic [IR_W-1:0] r_ir_q;
    logic            r_byp;
    logic            w_sel_id;
    logic            w_id_tdo;
    logic            w_sel_ext;
    logic            w_sel_byp;
    logic            w_dr_tdo;

    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn) r_state <= S_TLR;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_TLR:    w_state_nxt = TMS ? S_TLR    : S_RTI;
            S_RTI:    w_state_nxt = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_state_nxt = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_state_nxt = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_state_nxt = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_state_nxt = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_state_nxt = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_state_nxt = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_state_nxt = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_state_nxt = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_state_nxt = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_state_nxt = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_state_nxt = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_state_nxt = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_state_nxt = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_state_nxt = TMS ? S_SEL_DR : S_RTI;
            default:  w_state_nxt = S_TLR;
        endcase
    end

    // Entering TLR reloads the reset instruction on the same edge, so ir_q is
    // already correct in the first TLR cycle.
    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            r_ir_sh <= '0;
            r_ir_q  <= c_ir_rst;
        end else begin
            if (r_state == S_CAP_IR)     r_ir_sh <= IR_W'(1);
            else if (r_state == S_SH_IR) r_ir_sh <= {TDI, r_ir_sh[IR_W-1:1]};
            if (w_state_nxt == S_TLR)     r_ir_q <= c_ir_rst;
            else if (r_state == S_UPD_IR) r_ir_q <= r_ir_sh;
        end
    end

    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn)                                r_byp <= 1'b0;
        else if (w_sel_byp && r_state == S_CAP_DR) r_byp <= 1'b0;
        else if (w_sel_byp && r_state == S_SH_DR)  r_byp <= TDI;
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] r_id_sh;

    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn)                               r_id_sh <= '0;
        else if (w_sel_id && r_state == S_CAP_DR) r_id_sh <= IDCODE_VAL;
        else if (w_sel_id && r_state == S_SH_DR)  r_id_sh <= {TDI, r_id_sh[31:1]};
    end

    assign w_sel_id = (r_ir_q == OP_IDCODE);
    assign w_id_tdo = r_id_sh[0];
`else
    assign w_sel_id = 1'b0;
    assign w_id_tdo = 1'b0;
`endif

    assign sel_sample = (r_ir_q == OP_SAMPLE);
    assign sel_extest = (r_ir_q == OP_EXTEST);
    assign sel_intest = (r_ir_q == OP_INTEST);
    assign sel_bist   = (r_ir_q == OP_BIST);
    assign w_sel_ext  = sel_sample | sel_extest | sel_intest | sel_bist;
    assign w_sel_byp  = ~w_sel_ext & ~w_sel_id;

    always_comb begin
        w_dr_tdo = r_byp;
        if (w_sel_ext)     w_dr_tdo = ext_tdo;
        else if (w_sel_id) w_dr_tdo = w_id_tdo;
    end

    // TDO holds its last value outside the shift states.
    always_ff @(negedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end else begin
            TDO_en <= (r_state == S_SH_IR) || (r_state == S_SH_DR);
            if (r_state == S_SH_IR)      TDO <= r_ir_sh[0];
            else if (r_state == S_SH_DR) TDO <= w_dr_tdo;
        end
    end

    assign ir_q       = r_ir_q;
    assign tap_state  = r_state;
    assign tlr        = (r_state == S_TLR);
    assign capture_dr = (r_state == S_CAP_DR);
    assign shift_dr   = (r_state == S_SH_DR);
    assign update_dr  = (r_state == S_UPD_DR);

endmodule
`default_nettype wire
